rf_wb_buffer: RTL and testbench

//   Write-back buffer: the initiator side of the register-file write port (WR/RW/DW).

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_wb_buffer_if.sv | 38 +++
 rtl/rf_fwd_match.sv | 36 +++
 rtl/rf_wb_buffer.sv | 88 ++++++++
 tb/tb_rf_wb_buffer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and entry type for the register-file write-back path
package rf_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_XLEN = 32;

  typedef struct packed {
    logic [RF_AW-1:0]   rd;
    logic [RF_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_buffer_if.sv
// rtl/rf_wb_buffer_if.sv - write-back request, register-file write and snoop signals
interface rf_wb_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = rf_pkg::RF_AW,
  parameter int XLEN  = rf_pkg::RF_XLEN
);

  logic                     in_valid;
  logic                     in_ready;
  logic [AW-1:0]            in_rd;
  logic [XLEN-1:0]          in_data;
  logic                     rf_busy;
  logic                     WR;
  logic [AW-1:0]            RW;
  logic [XLEN-1:0]          DW;
  logic [AW-1:0]            RA;
  logic [AW-1:0]            RB;
  logic                     fwd_a_hit;
  logic [XLEN-1:0]          fwd_a_data;
  logic                     fwd_b_hit;
  logic [XLEN-1:0]          fwd_b_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;

  modport master (
    output in_valid, in_rd, in_data, rf_busy, RA, RB,
    input  in_ready, WR, RW, DW, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data,
           count, empty, full
  );

  modport slave (
    input  in_valid, in_rd, in_data, rf_busy, RA, RB,
    output in_ready, WR, RW, DW, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data,
           count, empty, full
  );

endinterface

// File: rtl/rf_fwd_match.sv
// rtl/rf_fwd_match.sv - youngest-match lookup of a register address over pending entries
// Entries are scanned oldest to youngest from the head, so the last match wins.
module rf_fwd_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int XLEN  = RF_XLEN
) (
  input  wb_entry_t               entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_idx_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [AW-1:0]            addr_i,
  output logic                     hit_o,
  output logic [XLEN-1:0]          data_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [IW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx_i + IW'(k);
      if ((PW'(k) < count_i) && (addr_i != '0) && (entries_i[idx].rd == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_wb_buffer.sv
// rtl/rf_wb_buffer.sv - write-back FIFO draining into the register-file write port
// Pending entries are forwarded to both read ports until they have been written.
module rf_wb_buffer
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int XLEN  = RF_XLEN
) (
  input  logic          HCLK,
  input  logic          HRESET,
  rf_wb_buffer_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t     mem_q [DEPTH];

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] count;
  wb_entry_t     head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // Writes to x0 are handshaken but never stored.
  assign push = bus.in_valid && !full && (bus.in_rd != '0);
  assign pop  = !empty && !bus.rf_busy;
  assign head = mem_q[rd_ptr_q[IW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= '{rd: bus.in_rd, data: bus.in_data};
    end
  end

  assign bus.in_ready = !full;
  assign bus.WR       = pop;
  assign bus.RW       = empty ? '0 : head.rd;
  assign bus.DW       = empty ? '0 : head.data;
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.full     = full;

  rf_fwd_match #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN)) u_fwd_a (
    .entries_i  (mem_q),
    .head_idx_i (rd_ptr_q[IW-1:0]),
    .count_i    (count),
    .addr_i     (bus.RA),
    .hit_o      (bus.fwd_a_hit),
    .data_o     (bus.fwd_a_data)
  );

  rf_fwd_match #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN)) u_fwd_b (
    .entries_i  (mem_q),
    .head_idx_i (rd_ptr_q[IW-1:0]),
    .count_i    (count),
    .addr_i     (bus.RB),
    .hit_o      (bus.fwd_b_hit),
    .data_o     (bus.fwd_b_data)
  );

endmodule

// File: tb/tb_rf_wb_buffer.sv
// tb/tb_rf_wb_buffer.sv - directed self-checking bench for rf_wb_buffer
module tb_rf_wb_buffer;

  logic HCLK;
  logic HRESET;
  int   checks;
  int   failures;

  rf_wb_buffer_if #(.DEPTH(4), .AW(5), .XLEN(32)) bus ();

  rf_wb_buffer #(.DEPTH(4), .AW(5), .XLEN(32)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    HRESET       = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rd    = '0;
    bus.in_data  = '0;
    bus.rf_busy  = 1'b0;
    bus.RA       = '0;
    bus.RB       = '0;

    // 1. reset and idle
    tick();
    tick();
    HRESET = 1'b0;
    tick();
    chk("rst_wr",       bus.WR, 0);
    chk("rst_empty",    bus.empty, 1);
    chk("rst_full",     bus.full, 0);
    chk("rst_count",    bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_fwd_a",    bus.fwd_a_hit, 0);
    chk("rst_rw",       bus.RW, 0);
    chk("rst_dw",       bus.DW, 0);

    // 2. single write, one-cycle latency
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd5;
    bus.in_data  = 32'h64;
    tick();
    bus.in_valid = 1'b0;
    bus.RA       = 5'd5;
    #1;
    chk("single_wr",    bus.WR, 1);
    chk("single_rw",    bus.RW, 5);
    chk("single_dw",    bus.DW, 32'h64);
    chk("single_count", bus.count, 1);
    chk("single_fwd_hit",  bus.fwd_a_hit, 1);
    chk("single_fwd_data", bus.fwd_a_data, 32'h64);
    tick();
    chk("single_empty", bus.empty, 1);
    chk("single_wr_off", bus.WR, 0);
    chk("single_fwd_gone", bus.fwd_a_hit, 0);

    // 3. fill while stalled, refuse fifth, drain in order
    bus.rf_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_rd    = 5'(i);
      bus.in_data  = 32'(i * 'h11);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("fill_full",     bus.full, 1);
    chk("fill_in_ready", bus.in_ready, 0);
    chk("fill_count",    bus.count, 4);
    chk("fill_wr_busy",  bus.WR, 0);
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd9;
    bus.in_data  = 32'h99;
    #1;
    chk("fifth_ready", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("fifth_count", bus.count, 4);
    bus.rf_busy = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_wr", bus.WR, 1);
      chk("drain_rw", bus.RW, 64'(i));
      chk("drain_dw", bus.DW, 64'(i * 'h11));
      tick();
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_wr_off", bus.WR, 0);

    // 4. youngest entry wins forwarding
    bus.rf_busy  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd20;
    bus.in_data  = 32'h0383;
    tick();
    bus.in_data  = 32'hFFFB6BC2;
    tick();
    bus.in_valid = 1'b0;
    bus.RA       = 5'd20;
    bus.RB       = 5'd10;
    #1;
    chk("fwd_a_hit",  bus.fwd_a_hit, 1);
    chk("fwd_a_data", bus.fwd_a_data, 32'hFFFB6BC2);
    chk("fwd_b_hit",  bus.fwd_b_hit, 0);
    chk("fwd_head_dw", bus.DW, 32'h0383);
    bus.rf_busy = 1'b0;
    tick();
    chk("fwd_after_pop_hit",  bus.fwd_a_hit, 1);
    chk("fwd_after_pop_data", bus.fwd_a_data, 32'hFFFB6BC2);
    chk("fwd_after_pop_dw",   bus.DW, 32'hFFFB6BC2);
    tick();
    chk("fwd_drained_hit", bus.fwd_a_hit, 0);
    chk("fwd_drained_empty", bus.empty, 1);

    // 5. x0 writes are accepted and dropped
    bus.RA       = 5'd0;
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd0;
    bus.in_data  = 32'hDEADBEEF;
    #1;
    chk("x0_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("x0_count", bus.count, 0);
    chk("x0_wr",    bus.WR, 0);
    chk("x0_fwd",   bus.fwd_a_hit, 0);
    tick();
    chk("x0_wr_later", bus.WR, 0);

    // 6. back-to-back stream: push and pop every cycle, pointers wrap
    bus.RA = 5'd3;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_rd    = 5'(i + 1);
      bus.in_data  = 32'h100 + 32'(i);
      tick();
      chk("stream_count", bus.count, 1);
      chk("stream_full",  bus.full, 0);
      chk("stream_wr",    bus.WR, 1);
      chk("stream_rw",    bus.RW, 64'(i + 1));
      chk("stream_dw",    bus.DW, 64'('h100 + i));
    end
    chk("stream_fwd_a_stale", bus.fwd_a_hit, 0);
    bus.in_rd   = 5'd7;
    bus.in_data = 32'h777;
    HRESET      = 1'b1;
    tick();
    HRESET       = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_wr",    bus.WR, 0);
    chk("midrst_count", bus.count, 0);
    tick();
    chk("midrst_idle_wr", bus.WR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
